alu_chain_sequencer: RTL

Multi-precision sequencer that sits directly upstream of the ALU and also consumes its results. It drives the ALU's A, B, FuncOp and IFlags ports one DataWidth word per cycle, least-significant word first. Carry is chained between words, and the per-word Y/OFlags are collected into a Words×DataWidth result with aggregate flags. The datapath uses it for wide add/sub/logic operations without adding a wider ALU.

---
 rtl/alu_chain_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_chain_sequencer.sv
// rtl/alu_chain_sequencer.sv - issues multi-word operations to a single-word ALU, LS word first
module alu_chain_sequencer #(
  parameter int DataWidth = 8,
  parameter int Words     = 4,
  parameter int FlagBits  = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [3:0]                 Op,
  input  logic                       CarryIn,
  input  logic [DataWidth*Words-1:0] OpA,
  input  logic [DataWidth*Words-1:0] OpB,
  output logic [DataWidth-1:0]       AluA,
  output logic [DataWidth-1:0]       AluB,
  output logic [3:0]                 AluFuncOp,
  output logic [FlagBits-1:0]        AluIFlags,
  input  logic [DataWidth-1:0]       AluY,
  input  logic [FlagBits-1:0]        AluOFlags,
  output logic [DataWidth*Words-1:0] Result,
  output logic [FlagBits-1:0]        Flags,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Err
);
  localparam logic [3:0] AddOp = 4'd0;
  localparam logic [3:0] SubOp = 4'd1;
  localparam logic [3:0] AndOp = 4'd2;
  localparam logic [3:0] OrOp  = 4'd3;
  localparam logic [3:0] XorOp = 4'd4;
  localparam logic [3:0] NotOp = 4'd5;
  localparam int FlagV = 3;
  localparam int FlagN = 2;
  localparam int FlagC = 1;
  localparam int FlagZ = 0;
  localparam int IdxW  = (Words > 1) ? $clog2(Words) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nx;
  logic [DataWidth-1:0]  a_q   [Words];
  logic [DataWidth-1:0]  b_q   [Words];
  logic [DataWidth-1:0]  res_q [Words];
  logic [3:0]            op_q;
  logic                  cin_q;
  logic                  zacc_q;
  logic [IdxW-1:0]       idx_q;
  logic [FlagBits-1:0]   flags_q;
  logic                  err_q;
  logic                  accept;
  logic                  supported;
  logic                  last_word;
  logic                  arith_q;

  assign supported = (Op == AddOp) || (Op == SubOp) || (Op == AndOp) ||
                     (Op == OrOp)  || (Op == XorOp) || (Op == NotOp);
  assign accept    = Start && (state != RUN);
  assign last_word = (idx_q == IdxW'(Words - 1));
  assign arith_q   = (op_q == AddOp) || (op_q == SubOp);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nx = supported ? RUN : DONE;
        else        state_nx = IDLE;
      end
      RUN:     if (last_word) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < Words; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
      op_q    <= '0;
      cin_q   <= 1'b0;
      zacc_q  <= 1'b0;
      idx_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        for (int i = 0; i < Words; i++) begin
          a_q[i] <= OpA[i*DataWidth +: DataWidth];
          b_q[i] <= OpB[i*DataWidth +: DataWidth];
        end
        op_q   <= Op;
        cin_q  <= (Op == AddOp) ? CarryIn : (Op == SubOp);
        idx_q  <= '0;
        zacc_q <= 1'b1;
        err_q  <= !supported;
      end else if (state == RUN) begin
        res_q[idx_q] <= AluY;
        cin_q        <= AluOFlags[FlagC];
        zacc_q       <= zacc_q & AluOFlags[FlagZ];
        idx_q        <= idx_q + 1'b1;
        if (last_word) begin
          flags_q        <= '0;
          flags_q[FlagV] <= AluOFlags[FlagV];
          flags_q[FlagN] <= AluOFlags[FlagN];
          flags_q[FlagC] <= arith_q & AluOFlags[FlagC];
          flags_q[FlagZ] <= zacc_q & AluOFlags[FlagZ];
        end
      end
    end
  end

  // Subtract is issued as A + ~B + carry so the borrow chains through the ALU's add path.
  always_comb begin
    AluA      = '0;
    AluB      = '0;
    AluIFlags = '0;
    AluFuncOp = op_q;
    if (state == RUN) begin
      AluA = a_q[idx_q];
      AluB = (op_q == SubOp) ? ~b_q[idx_q] : b_q[idx_q];
      if (op_q == SubOp) AluFuncOp = AddOp;
      AluIFlags[FlagC] = arith_q & cin_q;
    end
  end

  for (genvar g = 0; g < Words; g++) begin : g_result
    assign Result[g*DataWidth +: DataWidth] = res_q[g];
  end

  assign Flags = flags_q;
  assign Busy  = (state == RUN);
  assign Done  = (state == DONE);
  assign Err   = err_q;
endmodule
